// File: rtl/job_launcher_pkg.sv
// Shared types and default parameters for the job launcher slice.
package job_launcher_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LAUNCH   = 2'd1,
        WAIT     = 2'd2,
        COMPLETE = 2'd3
    } state_t;

    localparam int DEF_DEPTH   = 4;
    localparam int DEF_TAG_W   = 4;
    localparam int DEF_TIMEOUT = 255;
    localparam int DEF_CNT_W   = 8;

endpackage

// File: rtl/job_fifo.sv
// Circular tag buffer with extra-bit pointers; the head is read from storage
// and captured by the consumer on the pop edge.
module job_fifo
    import job_launcher_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int TAG_W = DEF_TAG_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [TAG_W-1:0]       wr_data,
    output logic [TAG_W-1:0]       rd_data,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [TAG_W-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic             full_s;
    logic             empty_s;
    logic             do_push_s;
    logic             do_pop_s;

    assign full_s    = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign empty_s   = (wr_ptr_r == rd_ptr_r);
    assign do_push_s = push && !full_s;
    assign do_pop_s  = pop && !empty_s;
    assign level     = wr_ptr_r - rd_ptr_r;
    assign rd_data   = mem_r[rd_ptr_r[AW-1:0]];

    // Storage write port; contents need no reset since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/job_launcher.sv
// Queues tagged jobs, launches them one at a time and reports completions.
// Optional watchdog enabled by defining JOB_LAUNCHER_WATCHDOG_EN.
module job_launcher
    import job_launcher_pkg::*;
#(
    parameter int DEPTH   = DEF_DEPTH,
    parameter int TAG_W   = DEF_TAG_W,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    input  logic [TAG_W-1:0]       req_tag,
    output logic                   req_ready,
    output logic                   start,
    input  logic                   done,
    output logic                   busy,
    output logic [TAG_W-1:0]       cur_tag,
    output logic                   cmp_valid,
    output logic [TAG_W-1:0]       cmp_tag,
    output logic                   cmp_timeout,
    output logic [CNT_W-1:0]       jobs_done,
    output logic [$clog2(DEPTH):0] fifo_level
);

    localparam int LVL_W = $clog2(DEPTH) + 1;

    state_t           state_r;
    state_t           state_next_s;
    logic [TAG_W-1:0] cur_tag_r;
    logic [TAG_W-1:0] head_s;
    logic [CNT_W-1:0] jobs_done_r;
    logic [LVL_W-1:0] level_s;
    logic             push_s;
    logic             pop_s;
    logic             expire_s;

    // Ready comes from the registered level only, so a full FIFO refuses even while popping.
    assign req_ready = (level_s != LVL_W'(DEPTH));
    assign push_s    = req_valid && req_ready;
    assign pop_s     = (state_r == IDLE) && (level_s != {LVL_W{1'b0}});

    job_fifo #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push_s),
        .pop     (pop_s),
        .wr_data (req_tag),
        .rd_data (head_s),
        .level   (level_s)
    );

`ifdef JOB_LAUNCHER_WATCHDOG_EN
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    logic [TMR_W-1:0] wait_cnt_r;
    logic             timeout_r;

    assign expire_s    = (state_r == WAIT) && (wait_cnt_r == TMR_W'(TIMEOUT - 1));
    assign cmp_timeout = timeout_r;

    // Wait timer and timeout flag; done in the expiry cycle clears the flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt_r <= {TMR_W{1'b0}};
            timeout_r  <= 1'b0;
        end else begin
            if (state_r == LAUNCH) begin
                wait_cnt_r <= {TMR_W{1'b0}};
            end else if ((state_r == WAIT) && (wait_cnt_r != {TMR_W{1'b1}})) begin
                wait_cnt_r <= wait_cnt_r + TMR_W'(1);
            end
            if (state_r == WAIT) begin
                timeout_r <= expire_s && !done;
            end
        end
    end
`else
    assign expire_s    = 1'b0;
    assign cmp_timeout = 1'b0;
`endif

    // Next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (level_s != {LVL_W{1'b0}}) begin
                    state_next_s = LAUNCH;
                end else begin
                    state_next_s = IDLE;
                end
            end
            LAUNCH:   state_next_s = WAIT;
            WAIT: begin
                if (done || expire_s) begin
                    state_next_s = COMPLETE;
                end else begin
                    state_next_s = WAIT;
                end
            end
            COMPLETE: state_next_s = IDLE;
            default:  state_next_s = IDLE;
        endcase
    end

    // State, current tag and completion counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            cur_tag_r   <= {TAG_W{1'b0}};
            jobs_done_r <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_next_s;
            if (pop_s) begin
                cur_tag_r <= head_s;
            end
            if (state_r == COMPLETE) begin
                jobs_done_r <= jobs_done_r + CNT_W'(1);
            end
        end
    end

    assign start      = (state_r == LAUNCH);
    assign busy       = (state_r == LAUNCH) || (state_r == WAIT);
    assign cmp_valid  = (state_r == COMPLETE);
    assign cur_tag    = cur_tag_r;
    assign cmp_tag    = cur_tag_r;
    assign jobs_done  = jobs_done_r;
    assign fifo_level = level_s;

endmodule
